// File: rtl/intt_twiddle_sequencer.sv
// ---------------------------------------------------------------------------
// intt_twiddle_sequencer
//
// Reads the 128-entry Kyber zeta ROM (q = 3329, normal domain) in inverse-NTT
// order and streams the negated twiddles (Q - zeta) to the INTT butterfly
// controller. There is one token per butterfly group: k runs 127 down to 1
// over layers len = 2..128. A final scale token (128^-1 mod Q) follows.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   start     one-cycle request to begin a sequence (ignored unless idle)
//   busy      high from the cycle after an accepted start until done
//   done      one-cycle pulse after the scale token handshakes
//   tw_addr   ROM address, equals k while fetching, 0 otherwise
//   tw_data   ROM data, combinational; only bits [11:0] are used
//   tw_valid  output token valid
//   tw_ready  consumer ready
//   tw_value  Q - zeta (0 if zeta == 0), or SCALE_F on the scale token
//   tw_layer  layer 0..6 (len = 2 << layer), 7 on the scale token
//   tw_group  group index within the layer, 0 on the scale token
//   tw_scale  marks the scale token
//   tw_last   marks the final token (same as tw_scale)
// ---------------------------------------------------------------------------
module intt_twiddle_sequencer #(
    parameter int unsigned Q       = 3329,
    parameter int unsigned SCALE_F = 3303
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [6:0]  tw_addr,
    input  logic [23:0] tw_data,
    output logic        tw_valid,
    input  logic        tw_ready,
    output logic [11:0] tw_value,
    output logic [2:0]  tw_layer,
    output logic [6:0]  tw_group,
    output logic        tw_scale,
    output logic        tw_last
);

    localparam logic [11:0] Q_W       = 12'(Q);
    localparam logic [11:0] SCALE_W   = 12'(SCALE_F);
    localparam logic [6:0]  K_FIRST   = 7'd127;
    localparam logic [2:0]  SCALE_LYR = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_SCALE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  k_q, k_d;
    logic [2:0]  layer_q, layer_d;
    logic [6:0]  group_q, group_d;

    // Next values of the registered outputs.
    logic        busy_d;
    logic        done_d;
    logic        valid_d;
    logic [11:0] value_d;
    logic [2:0]  tlayer_d;
    logic [6:0]  tgroup_d;
    logic        scale_d;
    logic        last_d;

    logic [11:0] zeta;
    logic [6:0]  group_inc;
    logic [6:0]  group_lim;

    // The upper half of the ROM word carries no information for this block.
    logic        unused_rom_hi;
    assign unused_rom_hi = ^tw_data[23:12];

    assign zeta      = tw_data[11:0];
    assign group_inc = group_q + 7'd1;
    // Layer L holds 64 >> L groups; layer_q never exceeds 6 while it is used.
    assign group_lim = 7'd64 >> layer_q;

    // The ROM read is combinational, so the address is only driven while
    // fetching; it rests at 0 so the unused entry 0 is the idle address.
    assign tw_addr = (state_q == S_FETCH) ? k_q : 7'd0;

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        k_d      = k_q;
        layer_d  = layer_q;
        group_d  = group_q;
        busy_d   = busy;
        done_d   = 1'b0;
        valid_d  = tw_valid;
        value_d  = tw_value;
        tlayer_d = tw_layer;
        tgroup_d = tw_group;
        scale_d  = tw_scale;
        last_d   = tw_last;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    k_d     = K_FIRST;
                    layer_d = 3'd0;
                    group_d = 7'd0;
                    busy_d  = 1'b1;
                end
            end

            S_FETCH: begin
                // Negate in the normal domain; zeta == 0 stays 0 rather than Q.
                value_d  = (zeta == 12'd0) ? 12'd0 : (Q_W - zeta);
                tlayer_d = layer_q;
                tgroup_d = group_q;
                valid_d  = 1'b1;
                state_d  = S_HOLD;
            end

            S_HOLD: begin
                // Outputs hold their registered values until the consumer
                // takes the token.
                if (tw_ready) begin
                    valid_d = 1'b0;
                    if (k_q == 7'd1) begin
                        state_d = S_SCALE;
                    end else begin
                        k_d = k_q - 7'd1;
                        if (group_inc == group_lim) begin
                            group_d = 7'd0;
                            layer_d = layer_q + 3'd1;
                        end else begin
                            group_d = group_inc;
                        end
                        state_d = S_FETCH;
                    end
                end
            end

            S_SCALE: begin
                // First cycle loads the scale token, then it waits for the
                // handshake like any other token.
                if (!tw_valid) begin
                    value_d  = SCALE_W;
                    tlayer_d = SCALE_LYR;
                    tgroup_d = 7'd0;
                    scale_d  = 1'b1;
                    last_d   = 1'b1;
                    valid_d  = 1'b1;
                end else if (tw_ready) begin
                    valid_d = 1'b0;
                    scale_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // start is deliberately not looked at here.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge value of the others, independent of statement order.
        if (rst) begin
            state_q  <= S_IDLE;
            k_q      <= 7'd0;
            layer_q  <= 3'd0;
            group_q  <= 7'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tw_valid <= 1'b0;
            tw_value <= 12'd0;
            tw_layer <= 3'd0;
            tw_group <= 7'd0;
            tw_scale <= 1'b0;
            tw_last  <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            layer_q  <= layer_d;
            group_q  <= group_d;
            busy     <= busy_d;
            done     <= done_d;
            tw_valid <= valid_d;
            tw_value <= value_d;
            tw_layer <= tlayer_d;
            tw_group <= tgroup_d;
            tw_scale <= scale_d;
            tw_last  <= last_d;
        end
    end

endmodule

// File: tb/tb_intt_twiddle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_intt_twiddle_sequencer
//
// Self-checking bench for intt_twiddle_sequencer. A behavioural zeta ROM
// drives tw_data from tw_addr. The expected 128-token stream is built from
// the ROM using the closed-form k -> (layer, group) mapping. Each run's
// handshakes are compared against it, alongside a table of hand-computed
// tokens and directed reset/backpressure/start-while-busy sequences.
// ---------------------------------------------------------------------------
module tb_intt_twiddle_sequencer;

    typedef struct packed {
        logic [11:0] value;
        logic [2:0]  layer;
        logic [6:0]  group;
        logic        scale;
        logic        last;
    } token_t;

    typedef struct {
        int     idx;   // handshake index within a run
        token_t exp;   // token expected at that index
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [6:0]  tw_addr;
    logic [23:0] tw_data;
    logic        tw_valid;
    logic        tw_ready;
    logic [11:0] tw_value;
    logic [2:0]  tw_layer;
    logic [6:0]  tw_group;
    logic        tw_scale;
    logic        tw_last;

    int zetas [0:127] = '{
           1, 1729, 2580, 3289, 2642,  630, 1897,  848,
        1062, 1919,  193,  797, 2786, 3260,  569, 1746,
         296, 2447, 1339, 1476, 3046,   56, 2240, 1333,
        1426, 2094,  535, 2882, 2393, 2879, 1974,  821,
         289,  331, 3253, 1756, 1197, 2304, 2277, 2055,
         650, 1977, 2513,  632, 2865,   33, 1320, 1915,
        2319, 1435,  807,  452, 1438, 2868, 1534, 2402,
        2647, 2617, 1481,  648, 2474, 3110, 1227,  910,
          17, 2761,  583, 2649, 1637,  723, 2288, 1100,
        1409, 2662, 3281,  233,  756, 2156, 3015, 3050,
        1703, 1651, 2789, 1789, 1847,  952, 1461, 2687,
         939, 2308, 2437, 2388,  733, 2337,  268,  641,
        1584, 2298, 2037, 3220,  375, 2549, 2090, 1645,
        1063,  319, 2773,  757, 2099,  561, 2466, 2594,
        2804, 1092,  403, 1026, 1143, 2150, 2775,  886,
        1722, 1212, 1874, 1029, 2110, 2935,  885, 2154
    };

    // Junk in the upper bits must not leak into the twiddle.
    assign tw_data = {12'hA5C, 12'(zetas[tw_addr])};

    intt_twiddle_sequencer #(
        .Q       (3329),
        .SCALE_F (3303)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .tw_addr  (tw_addr),
        .tw_data  (tw_data),
        .tw_valid (tw_valid),
        .tw_ready (tw_ready),
        .tw_value (tw_value),
        .tw_layer (tw_layer),
        .tw_group (tw_group),
        .tw_scale (tw_scale),
        .tw_last  (tw_last)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     n_done;
    token_t got[$];
    token_t exp_seq[$];
    vec_t   vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic token_t mk_tok(input int v, input int l, input int g, input bit s);
        token_t t;
        t.value = 12'(v);
        t.layer = 3'(l);
        t.group = 7'(g);
        t.scale = s;
        t.last  = s;
        return t;
    endfunction

    function automatic vec_t mk_vec(input int idx, input int v, input int l, input int g, input bit s);
        vec_t r;
        r.idx = idx;
        r.exp = mk_tok(v, l, g, s);
        return r;
    endfunction

    // Every output must sit at its reset value.
    task automatic check_quiet(input string tag);
        check({tag, "_busy"},  32'(busy),     32'd0);
        check({tag, "_done"},  32'(done),     32'd0);
        check({tag, "_valid"}, 32'(tw_valid), 32'd0);
        check({tag, "_value"}, 32'(tw_value), 32'd0);
        check({tag, "_layer"}, 32'(tw_layer), 32'd0);
        check({tag, "_group"}, 32'(tw_group), 32'd0);
        check({tag, "_scale"}, 32'(tw_scale), 32'd0);
        check({tag, "_last"},  32'(tw_last),  32'd0);
        check({tag, "_addr"},  32'(tw_addr),  32'd0);
    endtask

    // One full sequence: start from IDLE, collect handshakes until done.
    // Inputs change on the falling edge; the handshake recorded at a falling
    // edge is the one the DUT takes on the following rising edge.
    task automatic run_seq(input string tag, input bit rnd, input int stall_first,
                           input bit poke_start, output int done_cyc);
        int     cyc;
        int     stalls;
        bit     prev_stall;
        token_t prev_tok;
        token_t cur;
        got.delete();
        n_done     = 0;
        stalls     = 0;
        prev_stall = 1'b0;
        prev_tok   = '0;
        done_cyc   = -1;
        start      = 1'b1;
        tw_ready   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        forever begin
            cur = {tw_value, tw_layer, tw_group, tw_scale, tw_last};
            if (cyc == 0) begin
                check({tag, "_fetch_busy"},  32'(busy),     32'd1);
                check({tag, "_fetch_valid"}, 32'(tw_valid), 32'd0);
                check({tag, "_fetch_addr"},  32'(tw_addr),  32'd127);
            end
            if (cyc == 1)
                check({tag, "_first_valid"}, 32'(tw_valid), 32'd1);
            if (prev_stall) begin
                check({tag, "_stall_valid"}, 32'(tw_valid), 32'd1);
                check({tag, "_stall_token"}, 32'(cur), 32'(prev_tok));
            end
            if (stall_first > 0 && got.size() == 0)
                tw_ready = (stalls >= stall_first);
            else if (rnd)
                tw_ready = 1'($urandom_range(0, 1));
            else
                tw_ready = 1'b1;
            start = poke_start && (((cyc % 23) == 7) || done);
            if (tw_valid && !tw_ready)
                stalls++;
            prev_stall = tw_valid && !tw_ready;
            prev_tok   = cur;
            if (tw_valid && tw_ready)
                got.push_back(cur);
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            @(negedge clk);
            cyc++;
            if (n_done > 0 || cyc >= 2000)
                break;
        end
        start = 1'b0;
        if (done_cyc < 0)
            check({tag, "_timeout"}, 32'd0, 32'd1);
        // Back in IDLE: pulse over, no token, any start during DONE dropped.
        check({tag, "_post_done"},  32'(done),     32'd0);
        check({tag, "_post_busy"},  32'(busy),     32'd0);
        check({tag, "_post_valid"}, 32'(tw_valid), 32'd0);
    endtask

    task automatic compare_seq(input string tag);
        check({tag, "_count"}, 32'(got.size()), 32'd128);
        for (int i = 0; i < exp_seq.size() && i < got.size(); i++)
            check($sformatf("%s_tok%0d", tag, i), 32'(got[i]), 32'(exp_seq[i]));
        check({tag, "_done_pulses"}, 32'(n_done), 32'd1);
    endtask

    initial begin
        int dc;
        int cyc;

        // Reference stream: k in [64>>L, (128>>L)-1] is layer L, and groups
        // count up from the top k of the layer.
        for (int k = 127; k >= 1; k--) begin
            int l;
            int z;
            z = zetas[k];
            l = 0;
            while (k < (64 >> l))
                l++;
            exp_seq.push_back(mk_tok((z == 0) ? 0 : 3329 - z, l, (128 >> l) - 1 - k, 1'b0));
        end
        exp_seq.push_back(mk_tok(3303, 7, 0, 1'b1));

        // Hand-computed tokens from the ROM values.
        vecs[0] = mk_vec(0,   1175, 0, 0,  1'b0);  // ROM[127] = 2154
        vecs[1] = mk_vec(1,   2444, 0, 1,  1'b0);  // ROM[126] = 885
        vecs[2] = mk_vec(63,  3312, 0, 63, 1'b0);  // ROM[64]  = 17
        vecs[3] = mk_vec(64,  2419, 1, 0,  1'b0);  // ROM[63]  = 910
        vecs[4] = mk_vec(126, 1600, 6, 0,  1'b0);  // ROM[1]   = 1729
        vecs[5] = mk_vec(127, 3303, 7, 0,  1'b1);  // scale token

        rst      = 1'b1;
        start    = 1'b0;
        tw_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        @(negedge clk);
        check_quiet("idle");

        // Free-flowing consumer: two cycles per token.
        run_seq("base", 1'b0, 0, 1'b0, dc);
        compare_seq("base");
        check("base_cycles", 32'(dc), 32'd256);
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].idx < got.size())
                check($sformatf("vec_idx%0d", vecs[i].idx), 32'(got[vecs[i].idx]), 32'(vecs[i].exp));
            else
                check($sformatf("vec_idx%0d_missing", vecs[i].idx), 32'd0, 32'd1);
        end

        // Five stalled cycles on the first token.
        run_seq("stall", 1'b0, 5, 1'b0, dc);
        compare_seq("stall");
        check("stall_cycles", 32'(dc), 32'd261);

        // Random backpressure across the whole run.
        run_seq("rand", 1'b1, 0, 1'b0, dc);
        compare_seq("rand");

        // start pulsed while busy and during the done cycle.
        run_seq("poke", 1'b0, 0, 1'b1, dc);
        compare_seq("poke");
        check("poke_cycles", 32'(dc), 32'd256);

        // Reset in the middle of layer 3.
        start    = 1'b1;
        tw_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!(tw_valid && tw_layer == 3'd3) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reached_layer3", 32'(tw_valid && tw_layer == 3'd3), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("rst_mid");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rst_after%0d_done", i),  32'(done),     32'd0);
            check($sformatf("rst_after%0d_valid", i), 32'(tw_valid), 32'd0);
            check($sformatf("rst_after%0d_busy", i),  32'(busy),     32'd0);
        end

        // Fresh start after the abort, then a back-to-back run started the
        // cycle after done.
        run_seq("fresh", 1'b0, 0, 1'b0, dc);
        compare_seq("fresh");
        run_seq("b2b", 1'b0, 0, 1'b0, dc);
        compare_seq("b2b");
        check("b2b_cycles", 32'(dc), 32'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/intt_twiddle_sequencer.md
Name: intt_twiddle_sequencer

Overview:
- Reader and sequencer for the 128-entry Kyber zeta ROM (q = 3329, normal domain).
- Walks the inverse-NTT schedule: k = 127 down to 1, layers len = 2..128.
- Emits one negated twiddle (q - zeta) per butterfly group over a valid/ready stream, then one final scale token, 128^-1 mod q = 3303.
- Sits between the zeta ROM and the INTT butterfly datapath controller.

Parameters:
- Q, 3329, Kyber modulus
- SCALE_F, 3303, final INTT scale factor (128^-1 mod Q)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a sequence; ignored while busy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the scale token handshakes
- tw_addr  out  7  ROM address; equals k in FETCH, 0 otherwise
- tw_data  in  24  ROM data; only bits [11:0] (entry at tw_addr) are used
- tw_valid  out  1  output token valid
- tw_ready  in  1  consumer ready
- tw_value  out  12  Q - zeta, or 0 if zeta == 0; SCALE_F on the scale token
- tw_layer  out  3  layer index 0..6 (len = 2 << layer); 7 on the scale token
- tw_group  out  7  group index within the layer, 0..(64 >> layer) - 1; 0 on the scale token
- tw_scale  out  1  marks the scale token
- tw_last  out  1  marks the final token (same as the scale token)

Behaviour:
- Reset: all outputs 0; state IDLE; k = 0, layer = 0, group = 0.
- Reset asserted mid-sequence aborts it immediately: no done pulse, and outputs return to reset values next cycle.
- IDLE:
  - start = 1 -> k = 127, layer = 0, group = 0, busy = 1, next state FETCH.
- FETCH (one cycle):
  - tw_addr = k; ROM read is combinational.
  - Register tw_value = (z == 0) ? 0 : Q - z, where z = tw_data[11:0]; result is in 12 bits, range 1..3328.
  - Register tw_layer and tw_group; set tw_valid = 1; next state HOLD.
- HOLD:
  - All tw_* outputs stay stable while tw_valid && !tw_ready.
  - On handshake, tw_valid drops next cycle.
  - If k == 1 -> SCALE.
  - Else k -= 1 and group += 1; if group reaches (64 >> layer), group = 0 and layer += 1; next state FETCH.
- Throughput: one twiddle per 2 cycles with tw_ready held high. First tw_valid occurs 2 cycles after start.
- SCALE:
  - Present tw_value = SCALE_F, tw_layer = 7, tw_group = 0, tw_scale = 1, tw_last = 1, tw_valid = 1.
  - On handshake -> DONE.
- DONE (one cycle): done = 1, busy = 0, tw_valid = 0, tw_scale = 0, tw_last = 0; next state IDLE.
- Token count per sequence: 64 + 32 + 16 + 8 + 4 + 2 + 1 = 127 twiddles, plus 1 scale token = 128 handshakes.
- k maps to layer as follows: 127..64 -> layer 0, 63..32 -> 1, 31..16 -> 2, 15..8 -> 3, 7..4 -> 4, 3..2 -> 5, 1 -> 6.
- ROM entry 0 is never addressed.
- tw_ready is don't-care when tw_valid = 0.
- start while busy, or in the same cycle as done, is ignored. A new start is accepted in IDLE only.

Test Plan:
- Reset, then start with tw_ready = 1 -> cycle 2 after start: tw_value = 1175 (ROM[127] = 2154), layer 0, group 0. Next token: 2444 (ROM[126] = 885), group 1.
- Full run with tw_ready = 1 -> ROM[64] = 17 gives 3312 at layer 0, group 63. Next: ROM[63] = 910 gives 2419 at layer 1, group 0. k = 1 (ROM[1] = 1729) gives 1600 at layer 6, group 0. Then 3303 with tw_scale = tw_last = 1. done pulses once. Exactly 128 handshakes.
- Backpressure: tw_ready low for 5 cycles on the first token -> tw_value = 1175 and tw_valid remain stable, with no skipped or duplicated k; random ready over a full run still yields the same 128-token sequence.
- start pulsed while busy -> ignored; sequence and token count unchanged.
- rst asserted during layer 3 -> next cycle all outputs 0 and state IDLE, no done. A fresh start afterwards restarts at tw_value = 1175.
- Back-to-back runs: start the cycle after done -> second run identical to the first.
